// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port data RAM: the core has priority, and a
// starvation counter hands the DMA a bounded burst after MAXWAIT blocked cycles.
module ram_arbiter #(
  parameter int WIDTH   = 32,
  parameter int BURST   = 4,
  parameter int MAXWAIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [WIDTH-1:0] core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  output logic [WIDTH-1:0] core_rdata,
  output logic             core_stall,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [WIDTH-1:0] dma_addr,
  input  logic [WIDTH-1:0] dma_wdata,
  output logic             dma_gnt,
  output logic [WIDTH-1:0] dma_rdata,
  output logic [WIDTH-1:0] ram_address,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_enw,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [31:0]      stall_count
);
  localparam int WW = $clog2(MAXWAIT + 1);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MAXWAIT - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  typedef enum logic {CORE, DMA} owner_t;

  owner_t        r_owner, w_owner_nxt;
  logic [WW-1:0] r_waitcnt, w_waitcnt_nxt;
  logic [BW-1:0] r_burstcnt, w_burstcnt_nxt;
  logic          w_core_gnt, w_dma_gnt, w_core_stall;

  always_comb begin
    w_core_gnt     = 1'b0;
    w_dma_gnt      = 1'b0;
    w_core_stall   = 1'b0;
    w_owner_nxt    = r_owner;
    w_waitcnt_nxt  = r_waitcnt;
    w_burstcnt_nxt = r_burstcnt;
    case (r_owner)
      CORE: begin
        w_core_gnt = core_req;
        w_dma_gnt  = dma_req & ~core_req;
        if (core_req & dma_req) begin
          // Last blocked cycle: the core still gets this access, DMA owns the next one.
          if (r_waitcnt == WAIT_LAST) begin
            w_owner_nxt    = DMA;
            w_waitcnt_nxt  = '0;
            w_burstcnt_nxt = '0;
          end else begin
            w_waitcnt_nxt = r_waitcnt + 1'b1;
          end
        end else begin
          w_waitcnt_nxt = '0;
        end
      end
      DMA: begin
        w_dma_gnt    = dma_req;
        w_core_stall = core_req;
        if (!dma_req) begin
          w_owner_nxt   = CORE;
          w_waitcnt_nxt = '0;
        end else begin
          w_burstcnt_nxt = r_burstcnt + 1'b1;
          if (r_burstcnt == BURST_LAST) begin
            w_owner_nxt   = CORE;
            w_waitcnt_nxt = '0;
          end
        end
      end
      default: ;
    endcase
    if (reset) begin
      w_core_gnt   = 1'b0;
      w_dma_gnt    = 1'b0;
      w_core_stall = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner     <= CORE;
      r_waitcnt   <= '0;
      r_burstcnt  <= '0;
      stall_count <= '0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_waitcnt  <= w_waitcnt_nxt;
      r_burstcnt <= w_burstcnt_nxt;
      if (w_core_stall && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 1'b1;
    end
  end

  // With no grant the mux rests on the core side and the write enable stays low.
  assign ram_address = w_dma_gnt ? dma_addr  : core_addr;
  assign ram_wdata   = w_dma_gnt ? dma_wdata : core_wdata;
  assign ram_enw     = (w_core_gnt & core_we) | (w_dma_gnt & dma_we);
  assign dma_gnt     = w_dma_gnt;
  assign core_stall  = w_core_stall;
  assign core_rdata  = ram_rdata;
  assign dma_rdata   = ram_rdata;
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter that shares the single-port data RAM between the RISC-V core's load/store port and a DMA master (JPEG encoder output / host loader). It sits between the core, the DMA and the RAM, and muxes address, write data and write enable onto the RAM. The core normally has priority; a starvation counter guarantees the DMA a bounded-latency burst. Read data is routed back to both masters combinationally, because the RAM reads asynchronously and writes on the clock edge.

## Interface
Parameters:
- WIDTH, 32, data and address width
- BURST, 4, maximum consecutive DMA grants once the DMA owns the RAM (≥1)
- MAXWAIT, 8, consecutive blocked DMA cycles before ownership switches to the DMA (≥1)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- core_req  in  1  core load/store request this cycle
- core_we  in  1  core write (1) / read (0)
- core_addr  in  WIDTH  core address
- core_wdata  in  WIDTH  core write data
- core_rdata  out  WIDTH  RAM read data to the core (= ram_rdata)
- core_stall  out  1  core must hold its request; access not performed
- dma_req  in  1  DMA request this cycle
- dma_we  in  1  DMA write (1) / read (0)
- dma_addr  in  WIDTH  DMA address
- dma_wdata  in  WIDTH  DMA write data
- dma_gnt  out  1  DMA access performed this cycle
- dma_rdata  out  WIDTH  RAM read data to the DMA (= ram_rdata)
- ram_address  out  WIDTH  to RAM address
- ram_wdata  out  WIDTH  to RAM write data
- ram_enw  out  1  to RAM write enable
- ram_rdata  in  WIDTH  from RAM read data
- stall_count  out  32  number of core stall cycles since reset; saturates at 0xFFFF_FFFF

## Operation
- The state register `owner` is either CORE or DMA. Counters: `waitcnt` is $clog2(MAXWAIT+1) bits and `burstcnt` is $clog2(BURST+1) bits.
- Reset drives owner=CORE, waitcnt=0, burstcnt=0 and stall_count=0. While reset is high: ram_enw=0, dma_gnt=0, core_stall=0.
- CORE state:
  - core_stall=0.
  - The DMA uses idle cycles: dma_gnt = dma_req & ~core_req.
  - The RAM mux selects the core when core_req=1, otherwise the DMA.
- CORE state, waitcnt update:
  - If dma_req & core_req, waitcnt increments; otherwise waitcnt clears to 0.
  - When dma_req & core_req & waitcnt==MAXWAIT-1: owner becomes DMA and burstcnt clears to 0 at the next edge. The core access in that cycle still completes.
- DMA state:
  - dma_gnt = dma_req.
  - core_stall = core_req.
  - The RAM mux selects the DMA.
- DMA state, burstcnt update:
  - Each granted cycle increments burstcnt.
  - Owner returns to CORE (waitcnt cleared) at the edge where dma_req=0, or where a grant brings burstcnt to BURST.
- ram_enw:
  - equals (selected master's req) & (selected master's we);
  - is 0 when no master is granted. When nothing is granted the RAM address follows core_addr.
- Write and read semantics: writes commit at the edge ending the grant cycle. Read data is valid on core_rdata/dma_rdata during the grant cycle.
- stall_count increments in every cycle with core_stall=1 and holds at saturation.
- Masters must hold req, we, addr and wdata stable until the access is performed. A DMA that drops req in the DMA state forfeits the rest of its burst.

## Timing
- Core latency with no contention is 0 cycles (same-cycle access). A DMA using an idle cycle also has 0 latency.
- With continuous contention:
  - the DMA is blocked for exactly MAXWAIT cycles;
  - it is then granted for BURST consecutive cycles, during which the core stalls;
  - the pattern then repeats (MAXWAIT core cycles, BURST DMA cycles).
- Ownership changes take effect one cycle after the deciding edge. There are no dead cycles between owners.
- Reset asserted mid-burst: at the next edge the state is CORE with counters at zero, and no write occurs in the reset cycle.

## Test plan
- Core only, core_req=1, core_we=1, addr 0x10, data 0xDEADBEEF → ram_enw=1 the same cycle, core_stall=0; a read of 0x10 returns 0xDEADBEEF.
- DMA only, core_req=0, dma_req=1 for 3 cycles writing 0x20..0x22 → dma_gnt=1 every cycle, owner stays CORE, and the core reads back all three values.
- Continuous contention, MAXWAIT=8, BURST=4, both requesting for 30 cycles → dma_gnt pattern 8×0, 4×1, 8×0, 4×1…; stall_count=8 after the second burst.
- In DMA state, dma_req drops after 2 grants → owner returns to CORE at the next edge, core_stall drops to 0, waitcnt=0.
- Reset pulsed in the 2nd cycle of a DMA burst with dma_we=1 → no write to the RAM that cycle; after reset dma_gnt=0 while core_req=1, and stall_count=0.
- stall_count preloaded via force to 0xFFFFFFFE, 3 further stall cycles → reads 0xFFFFFFFF.
